div_arbiter: RTL and testbench

Arbitrating controller in front of the shared iterative divider (signed/unsigned, DATA_WIDTH cycles per operation). It accepts RISC-V M-extension divide/remainder requests from two requesters with round-robin arbitration and launches the divider. It resolves divide-by-zero and signed-overflow itself, without occupying the divider. It returns one tagged result per request through a single valid/ready response port.

---
 rtl/div_arbiter.sv | 159 +++++++++++++++
 tb/tb_div_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// div_arbiter: two-requester round-robin front end for a shared iterative divider; define DIV_ARB_RESULT_REUSE_EN for last-result reuse
module div_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_dividend,
  input  logic [DATA_WIDTH-1:0] req0_divisor,
  input  logic [1:0]            req0_op,
  input  logic [TAG_WIDTH-1:0]  req0_tag,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_dividend,
  input  logic [DATA_WIDTH-1:0] req1_divisor,
  input  logic [1:0]            req1_op,
  input  logic [TAG_WIDTH-1:0]  req1_tag,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [TAG_WIDTH-1:0]  resp_tag,
  output logic                  resp_src,
  output logic [DATA_WIDTH-1:0] div_dividend,
  output logic [DATA_WIDTH-1:0] div_divisor,
  output logic                  div_signed_ope,
  output logic                  div_start,
  output logic                  div_flush,
  input  logic [DATA_WIDTH-1:0] div_quotient,
  input  logic [DATA_WIDTH-1:0] div_remainder,
  input  logic                  div_ready
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  state_t                state_q, state_d;
  logic                  ptr_q, ptr_d, rem_q, rem_d, src_q, src_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                  sel, is_rem, zero_div, ovf, hit, special, grant;
  logic [1:0]            op;
  logic [TAG_WIDTH-1:0]  tag;
  logic [DATA_WIDTH-1:0] short_res, hit_res;
`ifdef DIV_ARB_RESULT_REUSE_EN
  logic                  rec_v_q, rec_s_q, lat_s_q;
  logic [DATA_WIDTH-1:0] rec_a_q, rec_b_q, rec_q_q, rec_r_q, lat_a_q, lat_b_q;
`endif

  assign div_flush  = flush;
  assign resp_valid = state_q == RESP;
  assign resp_data  = data_q;
  assign resp_tag   = tag_q;
  assign resp_src   = src_q;

  // Select a requester, classify its operation and decide whether it is granted this cycle
  always_comb begin
    sel            = (req0_valid && req1_valid) ? ptr_q : req1_valid;
    div_dividend   = sel ? req1_dividend : req0_dividend;
    div_divisor    = sel ? req1_divisor : req0_divisor;
    op             = sel ? req1_op : req0_op;
    tag            = sel ? req1_tag : req0_tag;
    is_rem         = op[1];
    div_signed_ope = ~op[0];
    zero_div       = div_divisor == '0;
    ovf            = div_signed_ope && div_dividend == MIN_NEG && div_divisor == '1;
`ifdef DIV_ARB_RESULT_REUSE_EN
    hit            = rec_v_q && rec_a_q == div_dividend && rec_b_q == div_divisor && rec_s_q == div_signed_ope;
    hit_res        = is_rem ? rec_r_q : rec_q_q;
`else
    hit            = 1'b0;
    hit_res        = '0;
`endif
    special        = zero_div || ovf || hit;
    grant          = rst_n && !flush && state_q == IDLE && (req0_valid || req1_valid) && (special || div_ready);
    req0_ready     = grant && !sel;
    req1_ready     = grant && sel;
    div_start      = grant && !special;
    short_res      = zero_div ? (is_rem ? div_dividend : '1) : ovf ? (is_rem ? '0 : div_dividend) : hit_res;
  end

  // Next state, pointer rotation and response capture
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    src_d   = src_q;
    tag_d   = tag_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (grant) begin
        state_d = special ? RESP : WAIT;
        ptr_d   = ~sel;
        rem_d   = is_rem;
        src_d   = sel;
        tag_d   = tag;
        data_d  = special ? short_res : data_q;
      end
      WAIT: if (div_ready) begin
        state_d = RESP;
        data_d  = rem_q ? div_remainder : div_quotient;
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Controller state and held response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      rem_q   <= 1'b0;
      src_q   <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      src_q   <= src_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

`ifdef DIV_ARB_RESULT_REUSE_EN
  // Remember launched operands and record every completed division for reuse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rec_v_q <= 1'b0;
      rec_s_q <= 1'b0;
      rec_a_q <= '0;
      rec_b_q <= '0;
      rec_q_q <= '0;
      rec_r_q <= '0;
      lat_s_q <= 1'b0;
      lat_a_q <= '0;
      lat_b_q <= '0;
    end else begin
      if (div_start) begin
        lat_a_q <= div_dividend;
        lat_b_q <= div_divisor;
        lat_s_q <= div_signed_ope;
      end
      if (flush) rec_v_q <= 1'b0;
      else if (state_q == WAIT && div_ready) begin
        rec_v_q <= 1'b1;
        rec_a_q <= lat_a_q;
        rec_b_q <= lat_b_q;
        rec_s_q <= lat_s_q;
        rec_q_q <= div_quotient;
        rec_r_q <= div_remainder;
      end
    end
  end
`endif
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: randomized and directed check of div_arbiter against a transaction-level model
module tb_div_arbiter;
  localparam int W  = 32;
  localparam int TW = 4;

  logic          clk, rst_n, flush;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0]  req0_dividend, req0_divisor, req1_dividend, req1_divisor;
  logic [1:0]    req0_op, req1_op;
  logic [TW-1:0] req0_tag, req1_tag;
  logic          resp_valid, resp_ready, resp_src;
  logic [W-1:0]  resp_data;
  logic [TW-1:0] resp_tag;
  logic [W-1:0]  div_dividend, div_divisor, div_quotient, div_remainder;
  logic          div_signed_ope, div_start, div_flush, div_ready;

  int n_chk = 0;
  int n_pass = 0;

  div_arbiter #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_dividend(req0_dividend),
    .req0_divisor(req0_divisor), .req0_op(req0_op), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_dividend(req1_dividend),
    .req1_divisor(req1_divisor), .req1_op(req1_op), .req1_tag(req1_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_src(resp_src),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_signed_ope(div_signed_ope),
    .div_start(div_start), .div_flush(div_flush), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .div_ready(div_ready)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // RISC-V M-extension divide/remainder semantics
  function automatic logic [W-1:0] ref_res(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return o[1] ? a : '1;
    if (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return o[1] ? '0 : a;
    if (!o[0]) return o[1] ? W'($signed(a) % $signed(b)) : W'($signed(a) / $signed(b));
    return o[1] ? a % b : a / b;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    $display("FAIL %s: got no handshake expected one within 200 cycles", nm);
  endtask

  // Bench divider: busy for W cycles after a start, aborted by div_flush
  int dcnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt <= 0;
      div_quotient <= '0;
      div_remainder <= '0;
    end else if (div_flush) dcnt <= 0;
    else if (div_start) begin
      dcnt <= W - 1;
      div_quotient <= ref_res({1'b0, !div_signed_ope}, div_dividend, div_divisor);
      div_remainder <= ref_res({1'b1, !div_signed_ope}, div_dividend, div_divisor);
    end else if (dcnt > 0) dcnt <= dcnt - 1;
  end
  assign div_ready = dcnt == 0;

  // Transaction-level model state
  bit           m_ptr, m_pend, m_div, m_sg, m_src;
  int           m_left;
  logic [W-1:0] m_a, m_b, m_data;
  logic [TW-1:0] m_tag;
  bit           m_rec_v = 0;
  logic [W-1:0] m_rec_a, m_rec_b;
  bit           m_rec_s;

  // Compare DUT outputs with the model every cycle and advance the model to the next edge
  always @(negedge clk) begin : cmp
    logic s, sg, sh, g;
    logic [W-1:0] a, b;
    logic [1:0] o;
    if (!rst_n) begin
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_div_start", div_start, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_resp_tag", resp_tag, 0);
      chk("rst_resp_src", resp_src, 0);
      m_ptr = 0;
      m_pend = 0;
      m_rec_v = 0;
    end else begin
      chk("div_flush", div_flush, flush);
      if (m_pend) begin
        chk("busy_req0_ready", req0_ready, 0);
        chk("busy_req1_ready", req1_ready, 0);
        chk("busy_div_start", div_start, 0);
        chk("resp_valid", resp_valid, m_left == 0);
        if (m_left == 0) begin
          chk("resp_data", resp_data, m_data);
          chk("resp_tag", resp_tag, m_tag);
          chk("resp_src", resp_src, m_src);
          if (resp_ready) m_pend = 0;
        end else begin
`ifdef DIV_ARB_RESULT_REUSE_EN
          if (m_div && m_left == 1 && !flush) begin
            m_rec_v = 1;
            m_rec_a = m_a;
            m_rec_b = m_b;
            m_rec_s = m_sg;
          end
`endif
          m_left--;
        end
      end else begin
        s = (req0_valid && req1_valid) ? m_ptr : req1_valid;
        a = s ? req1_dividend : req0_dividend;
        b = s ? req1_divisor : req0_divisor;
        o = s ? req1_op : req0_op;
        sg = !o[0];
        sh = b == 0 || (sg && a == 32'h80000000 && b == 32'hFFFFFFFF) ||
             (m_rec_v && a == m_rec_a && b == m_rec_b && sg == m_rec_s);
        g = (req0_valid || req1_valid) && !flush && (sh || div_ready);
        chk("req0_ready", req0_ready, g && !s);
        chk("req1_ready", req1_ready, g && s);
        chk("div_start", div_start, g && !sh);
        chk("idle_resp_valid", resp_valid, 0);
        if (g && !sh) begin
          chk("div_dividend", div_dividend, a);
          chk("div_divisor", div_divisor, b);
          chk("div_signed_ope", div_signed_ope, sg);
        end
        if (g) begin
          m_pend = 1;
          m_left = sh ? 0 : W;
          m_div = !sh;
          m_a = a;
          m_b = b;
          m_sg = sg;
          m_data = ref_res(o, a, b);
          m_tag = s ? req1_tag : req0_tag;
          m_src = s;
          m_ptr = !s;
        end
      end
      if (flush) begin
        m_pend = 0;
        m_rec_v = 0;
      end
    end
  end

  task automatic send(input bit s, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] t, input bit wait_resp);
    bit got;
    int n;
    @(posedge clk); #1;
    if (s) begin
      req1_valid = 1; req1_op = o; req1_dividend = a; req1_divisor = b; req1_tag = t;
    end else begin
      req0_valid = 1; req0_op = o; req0_dividend = a; req0_divisor = b; req0_tag = t;
    end
    got = 0;
    for (n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = s ? req1_ready : req0_ready;
    end
    if (!got) timeout("grant");
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 0;
    if (wait_resp) begin
      got = 0;
      for (n = 0; n < 200 && !got; n++) begin
        @(negedge clk);
        got = resp_valid && resp_ready;
      end
      if (!got) timeout("response");
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 0;
      1: return 1;
      2: return 7;
      3: return 32'hFFFFFFF9;
      4: return 32'h80000000;
      5: return 32'hFFFFFFFF;
      6: return 100;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 0; flush = 0; resp_ready = 1;
    req0_valid = 0; req0_dividend = 0; req0_divisor = 0; req0_op = 0; req0_tag = 0;
    req1_valid = 0; req1_dividend = 0; req1_divisor = 0; req1_op = 0; req1_tag = 0;
    chk("pin_divu", ref_res(2'b01, 100, 7), 14);
    chk("pin_div_neg", ref_res(2'b00, 32'hFFFFFFF9, 2), 32'hFFFFFFFD);
    chk("pin_rem_neg", ref_res(2'b10, 32'hFFFFFFF9, 2), 32'hFFFFFFFF);
    chk("pin_divu_zero", ref_res(2'b01, 5, 0), 32'hFFFFFFFF);
    chk("pin_remu_zero", ref_res(2'b11, 5, 0), 5);
    chk("pin_div_ovf", ref_res(2'b00, 32'h80000000, 32'hFFFFFFFF), 32'h80000000);
    chk("pin_rem_ovf", ref_res(2'b10, 32'h80000000, 32'hFFFFFFFF), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    send(0, 2'b01, 100, 7, 3, 1);
    send(0, 2'b00, 32'hFFFFFFF9, 2, 1, 1);
    send(0, 2'b10, 32'hFFFFFFF9, 2, 2, 1);
    send(1, 2'b01, 5, 0, 4, 1);
    send(1, 2'b11, 5, 0, 5, 1);
    send(0, 2'b00, 32'h80000000, 32'hFFFFFFFF, 6, 1);
    send(0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 7, 1);
    // both requesters held valid straight out of reset
    @(posedge clk); #1;
    rst_n = 0;
    req0_valid = 1; req0_op = 2'b01; req0_dividend = 100; req0_divisor = 7; req0_tag = 8;
    req1_valid = 1; req1_op = 2'b11; req1_dividend = 5; req1_divisor = 0; req1_tag = 9;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (200) @(posedge clk);
    #1 req0_valid = 0; req1_valid = 0;
    repeat (40) @(posedge clk);
    // flush in cycle 10 of a divider operation
    send(0, 2'b01, 1000, 3, 10, 0);
    repeat (9) @(posedge clk);
    #1 flush = 1;
    @(posedge clk);
    #1 flush = 0;
    send(1, 2'b01, 1000, 3, 11, 1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst_n = !(i >= 1500 && i < 1502);
      req0_valid = $urandom_range(0, 3) != 0;
      req1_valid = $urandom_range(0, 3) != 0;
      req0_dividend = pick(); req0_divisor = pick(); req0_op = 2'($urandom); req0_tag = 4'($urandom);
      req1_dividend = pick(); req1_divisor = pick(); req1_op = 2'($urandom); req1_tag = 4'($urandom);
      resp_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 59) == 0;
    end
    @(posedge clk); #1;
    rst_n = 1; flush = 0; resp_ready = 1; req0_valid = 0; req1_valid = 0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
